// File: rtl/warp_regfile.sv
// Banked SIMD register file: NUM_WARPS x NUM_REGS x NUM_LANES, 2 read / 1 write.
// Define WARP_REGFILE_BYPASS_EN to forward same-cycle write data to colliding reads.
module warp_regfile #(
    parameter int NUM_LANES = 8,
    parameter int NUM_WARPS = 8,
    parameter int NUM_REGS  = 64,
    parameter int DATA_W    = 64,
    localparam int WW = $clog2(NUM_WARPS),
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_req,
    output logic                        ready,
    input  logic [NUM_LANES-1:0]        write_en,
    input  logic [WW-1:0]               wwarp,
    input  logic [AW-1:0]               waddr,
    input  logic [NUM_LANES*DATA_W-1:0] wdata,
    input  logic [NUM_LANES-1:0]        read_en_0,
    input  logic [WW-1:0]               rwarp_0,
    input  logic [AW-1:0]               raddr_0,
    output logic [NUM_LANES*DATA_W-1:0] rdata_0,
    output logic                        rvalid_0,
    input  logic [NUM_LANES-1:0]        read_en_1,
    input  logic [WW-1:0]               rwarp_1,
    input  logic [AW-1:0]               raddr_1,
    output logic [NUM_LANES*DATA_W-1:0] rdata_1,
    output logic                        rvalid_1
);
    localparam int DEPTH = NUM_WARPS * NUM_REGS;
    localparam int CW    = WW + AW + 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 clr_we;
    logic [WW+AW-1:0]     widx, ridx_0, ridx_1;
    logic [NUM_LANES-1:0] hit_0, hit_1;

    logic [DATA_W-1:0] mem [DEPTH][NUM_LANES];

    assign widx   = {wwarp, waddr};
    assign ridx_0 = {rwarp_0, raddr_0};
    assign ridx_1 = {rwarp_1, raddr_1};
    assign ready  = (state == RUN);

`ifdef WARP_REGFILE_BYPASS_EN
    assign hit_0 = (widx == ridx_0) ? write_en : '0;
    assign hit_1 = (widx == ridx_1) ? write_en : '0;
`else
    assign hit_0 = '0;
    assign hit_1 = '0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        unique case (state)
            CLEAR: begin
                if (clear_req) begin
                    cnt_nx = '0;
                end else if (cnt == CW'(DEPTH)) begin
                    state_nx = RUN;
                end else begin
                    clr_we = 1'b1;
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Storage is never reset directly; the zero-fill walk covers it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                for (int i = 0; i < NUM_LANES; i++)
                    mem[cnt[CW-2:0]][i] <= '0;
            end else if (ready) begin
                for (int i = 0; i < NUM_LANES; i++)
                    if (write_en[i])
                        mem[widx][i] <= wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_0  <= '0;
            rdata_1  <= '0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
        end else begin
            rvalid_0 <= ready & (|read_en_0);
            rvalid_1 <= ready & (|read_en_1);
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ready && read_en_0[i])
                    rdata_0[i*DATA_W +: DATA_W] <= hit_0[i] ?
                        wdata[i*DATA_W +: DATA_W] : mem[ridx_0][i];
                if (ready && read_en_1[i])
                    rdata_1[i*DATA_W +: DATA_W] <= hit_1[i] ?
                        wdata[i*DATA_W +: DATA_W] : mem[ridx_1][i];
            end
        end
    end

endmodule

// File: tb/tb_warp_regfile.sv
// Directed self-checking bench for warp_regfile (default parameters).
// Honours WARP_REGFILE_BYPASS_EN for the collision expectation.
module tb_warp_regfile;
    localparam int NL = 8;
    localparam int DW = 64;
    localparam int W  = NL * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          ready;
    logic [NL-1:0] write_en = '0;
    logic [2:0]    wwarp = '0;
    logic [5:0]    waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [NL-1:0] read_en_0 = '0;
    logic [2:0]    rwarp_0 = '0;
    logic [5:0]    raddr_0 = '0;
    logic [W-1:0]  rdata_0;
    logic          rvalid_0;
    logic [NL-1:0] read_en_1 = '0;
    logic [2:0]    rwarp_1 = '0;
    logic [5:0]    raddr_1 = '0;
    logic [W-1:0]  rdata_1;
    logic          rvalid_1;

    int checks = 0;
    int errors = 0;

    warp_regfile dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
        .write_en(write_en), .wwarp(wwarp), .waddr(waddr), .wdata(wdata),
        .read_en_0(read_en_0), .rwarp_0(rwarp_0), .raddr_0(raddr_0),
        .rdata_0(rdata_0), .rvalid_0(rvalid_0),
        .read_en_1(read_en_1), .rwarp_1(rwarp_1), .raddr_1(raddr_1),
        .rdata_1(rdata_1), .rvalid_1(rvalid_1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] w, input logic [5:0] r,
                      input logic [NL-1:0] en, input logic [W-1:0] d);
        write_en = en; wwarp = w; waddr = r; wdata = d;
        tick;
        write_en = '0;
    endtask

    task automatic rd0(input logic [2:0] w, input logic [5:0] r,
                       input logic [NL-1:0] en);
        read_en_0 = en; rwarp_0 = w; raddr_0 = r;
        tick;
        read_en_0 = '0;
    endtask

    task automatic rd_both(input logic [2:0] w, input logic [5:0] r);
        read_en_0 = '1; rwarp_0 = w; raddr_0 = r;
        read_en_1 = '1; rwarp_1 = w; raddr_1 = r;
        tick;
        read_en_0 = '0; read_en_1 = '0;
    endtask

    function automatic logic [W-1:0] rep(input logic [DW-1:0] d);
        return {NL{d}};
    endfunction

    initial begin
        logic [W-1:0]    d, pa, pb, held, expv;
        logic [DW-1:0]   lane;
        int              lows;
        logic            bad;
        logic [2:0]      tw [4];
        logic [5:0]      tr [4];

        tw[0] = 3'd0; tr[0] = 6'd0;
        tw[1] = 3'd7; tr[1] = 6'd63;
        tw[2] = 3'd1; tr[2] = 6'd7;
        tw[3] = 3'd2; tr[3] = 6'd5;

        tick;
        tick;
        check("rst_ready", W'(ready), W'(0));
        check("rst_rvalid", W'({rvalid_0, rvalid_1}), W'(0));
        check("rst_rdata_0", rdata_0, '0);
        check("rst_rdata_1", rdata_1, '0);

        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 600 && !ready; k++) begin
            tick;
            if (!ready) lows++;
        end
        check("init_lows", W'(lows), W'(512));
        check("init_ready", W'(ready), W'(1));

        for (int t = 0; t < 4; t++) begin
            rd_both(tw[t], tr[t]);
            check("dflt_rd0", rdata_0, '0);
            check("dflt_rd1", rdata_1, '0);
            check("dflt_rv", W'({rvalid_0, rvalid_1}), W'(2'b11));
        end

        for (int w = 0; w < 8; w++) begin
            for (int r = 0; r < 64; r++) begin
                for (int l = 0; l < NL; l++)
                    d[l*DW +: DW] = {$urandom, $urandom};
                wr(3'(w), 6'(r), 8'hFF, d);
                rd0(3'(w), 6'(r), 8'hFF);
                check("sw_p0", rdata_0, d);
                check("sw_p0_rv", W'({rvalid_0, rvalid_1}), W'(2'b10));
                read_en_1 = '1; rwarp_1 = 3'(w); raddr_1 = 6'(r);
                tick;
                read_en_1 = '0;
                check("sw_p1", rdata_1, d);
                check("sw_p1_rv", W'({rvalid_0, rvalid_1}), W'(2'b01));
                rd_both(3'(w), 6'(r));
                check("sw_b0", rdata_0, d);
                check("sw_b1", rdata_1, d);
                check("sw_b_rv", W'({rvalid_0, rvalid_1}), W'(2'b11));
            end
        end

        wr(3'd1, 6'd7, 8'hFF, rep(64'h1111));
        write_en = 8'hFF; wwarp = 3'd1; waddr = 6'd7; wdata = rep(64'h2222);
        read_en_0 = 8'hFF; rwarp_0 = 3'd1; raddr_0 = 6'd7;
        tick;
        write_en = '0; read_en_0 = '0;
`ifdef WARP_REGFILE_BYPASS_EN
        check("coll_same", rdata_0, rep(64'h2222));
`else
        check("coll_same", rdata_0, rep(64'h1111));
`endif
        rd0(3'd1, 6'd7, 8'hFF);
        check("coll_next", rdata_0, rep(64'h2222));

        held = rdata_0;
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        write_en = 8'hFF; wwarp = 3'd0; waddr = 6'd0; wdata = rep(64'hDEAD);
        read_en_0 = 8'hFF; rwarp_0 = 3'd0; raddr_0 = 6'd0;
        read_en_1 = 8'hFF; rwarp_1 = 3'd7; raddr_1 = 6'd63;
        check("clr_ready", W'(ready), W'(0));
        lows = 1;
        bad = 1'b0;
        for (int k = 0; k < 700 && !ready; k++) begin
            if (rvalid_0 || rvalid_1 || rdata_0 !== held) bad = 1'b1;
            tick;
            if (!ready) lows++;
        end
        write_en = '0; read_en_0 = '0; read_en_1 = '0;
        check("clr_ignored", W'(bad), W'(0));
        check("clr_lows_ok", W'(lows >= 512 && lows <= 513), W'(1));
        check("clr_ready_up", W'(ready), W'(1));
        for (int t = 0; t < 4; t++) begin
            rd_both(tw[t], tr[t]);
            check("clr_rd0", rdata_0, '0);
            check("clr_rd1", rdata_1, '0);
        end

        wr(3'd2, 6'd5, 8'h08, rep(64'hA5A5));
        rd0(3'd3, 6'd5, 8'hFF);
        check("iso_other_warp", rdata_0, '0);
        rd0(3'd2, 6'd5, 8'hFF);
        expv = '0;
        expv[3*DW +: DW] = 64'hA5A5;
        check("iso_lanes", rdata_0, expv);

        for (int l = 0; l < NL; l++) begin
            lane = {32'hAAAA0000 + 32'(l), 32'h1234_5678};
            pa[l*DW +: DW] = lane;
            lane = {32'hBBBB0000 + 32'(l), 32'h8765_4321};
            pb[l*DW +: DW] = lane;
        end
        wr(3'd4, 6'd9, 8'hFF, pa);
        wr(3'd5, 6'd10, 8'hFF, pb);
        rd0(3'd4, 6'd9, 8'hFF);
        check("part_pre", rdata_0, pa);
        rd0(3'd5, 6'd10, 8'h0F);
        expv = {pa[W-1:W/2], pb[W/2-1:0]};
        check("part_hold", rdata_0, expv);
        check("part_rv", W'(rvalid_0), W'(1));
        tick;
        check("rv_drop", W'({rvalid_0, rvalid_1}), W'(0));
        check("rdata_hold", rdata_0, expv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/warp_regfile.md
WARP_REGFILE -- requirements
Module: warp_regfile

Interface
REQ-001 Parameter NUM_LANES, default 8: number of SIMD lanes.
REQ-002 Parameter NUM_WARPS, default 8: number of warp contexts (power of two, >=2).
REQ-003 Parameter NUM_REGS, default 64: registers per warp per lane (power of two, >=2).
REQ-004 Parameter DATA_W, default 64: register width in bits.
REQ-005 Derived widths SHALL be WW = clog2(NUM_WARPS) and AW = clog2(NUM_REGS).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 clear_req  input  1  one-cycle pulse requesting a full zero-fill.
REQ-009 ready  output  1  high when the file accepts reads/writes.
REQ-010 write_en  input  NUM_LANES  per-lane write enable.
REQ-011 wwarp  input  WW  write warp index.
REQ-012 waddr  input  AW  write register index.
REQ-013 wdata  input  NUM_LANES*DATA_W  packed write data, lane i at [i*DATA_W +: DATA_W].
REQ-014 read_en_0 / read_en_1  input  NUM_LANES each  per-lane read enable, ports 0/1.
REQ-015 rwarp_0 / rwarp_1  input  WW each  read warp index per port.
REQ-016 raddr_0 / raddr_1  input  AW each  read register index per port.
REQ-017 rdata_0 / rdata_1  output  NUM_LANES*DATA_W each  registered packed read data.
REQ-018 rvalid_0 / rvalid_1  output  1 each  read data valid strobe per port.

Function
REQ-019 Storage SHALL be NUM_WARPS x NUM_REGS x NUM_LANES entries of DATA_W bits.
REQ-020 FSM states SHALL be CLEAR and RUN; ready = (state == RUN).
REQ-021 In CLEAR, a counter SHALL walk entries {warp,reg} from 0 to NUM_WARPS*NUM_REGS-1, one per cycle, zeroing all lanes; CLEAR->RUN on the cycle after the last entry is zeroed.
REQ-022 In RUN, clear_req=1 SHALL move to CLEAR with counter 0; in CLEAR, clear_req SHALL restart the counter at 0.
REQ-023 While ready=0, write_en, read_en_0 and read_en_1 SHALL be ignored; rvalid_0/1 SHALL be 0.
REQ-024 In RUN, lane i SHALL write wdata lane i to [wwarp][waddr][i] at the edge when write_en[i]=1.
REQ-025 Read latency SHALL be 1 cycle: request at edge N, rdata/rvalid valid after edge N.
REQ-026 rvalid_p SHALL be registered as ready & |read_en_p.
REQ-027 Lane i of rdata_p SHALL update only when read_en_p[i]=1 and ready=1; otherwise hold its last value.
REQ-028 Both ports SHALL be independent; same-entry reads on both ports SHALL return identical data.
REQ-029 A write and a read in the same cycle to different entries SHALL not interact.
REQ-030 Same-cycle write and read hitting the same warp, register and lane: behaviour per REQ-034/REQ-035.
REQ-031 Indices SHALL not wrap beyond range; NUM_* powers of two make every index legal.

Reset
REQ-032 rst=1 SHALL force state CLEAR, counter 0, rdata_0/1 = 0, rvalid_0/1 = 0, ready = 0; it takes priority over clear_req and all requests.
REQ-033 rst asserted mid-CLEAR or mid-RUN SHALL restart zero-fill from entry 0; ready rises exactly NUM_WARPS*NUM_REGS cycles after the edge where rst is sampled 0.

Configuration
REQ-034 With WARP_REGFILE_BYPASS_EN defined, a same-cycle write/read collision (REQ-030) SHALL return the newly written data on that lane.
REQ-035 Without WARP_REGFILE_BYPASS_EN, the collision SHALL return the value stored before the write (read-before-write).

Verification
REQ-036 Reset release, defaults: ready=0 for 512 cycles, then 1; all reads of any warp/reg/lane -> 0.
REQ-037 Per-warp sweep: for each of 8 warps x 64 regs, write random data to all lanes (write_en=8'hFF), next cycle read same entry on port 0, then port 1, then both -> each rdata equals written data, rvalid=1.
REQ-038 Warp isolation: write 64'hA5A5 to warp 2 reg 5 lane 3 only (write_en=8'h08) -> warp 3 reg 5 reads 0; warp 2 reg 5 other lanes read 0; lane 3 reads 64'hA5A5.
REQ-039 Collision: warp 1 reg 7 holds 64'h1111; same cycle write 64'h2222 and read port 0 -> 64'h2222 with bypass macro, 64'h1111 without; next read -> 64'h2222 either way.
REQ-040 Clear mid-operation: after writes, pulse clear_req -> ready=0 for 512 cycles, reads/writes ignored (rvalid=0), then all entries read 0.
REQ-041 Partial enable hold: rdata_0 lanes = X; read with read_en_0=8'h0F -> lanes 0-3 update, lanes 4-7 keep X.
